acc_collector: RTL and testbench

- Read side of the per-core accumulator interface.
- On the `update` pulse, every core presents its accumulator on `acc`; this block captures all NUM_CORES words in one cycle.
- It then serializes the captured words, core 0 first, onto a valid/ready stream toward the host-side DMA.
- It frees the cores to start the next accumulation immediately, and flags any result frame lost because the stream is still draining.

---
 rtl/hpu_pkg.sv | 13 +
 rtl/acc_collector_if.sv | 16 +
 rtl/acc_collector.sv | 123 ++++++++++++
 tb/tb_acc_collector.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/hpu_pkg.sv
// Shared definitions for the HPU core array and its host-side collectors.
package hpu_pkg;

    localparam int unsigned DEF_NUM_CORES = 8;
    localparam int unsigned DEF_DATA_W    = 32;
    localparam int unsigned IDX_W         = $clog2(DEF_NUM_CORES);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } collector_state_t;

endpackage

// File: rtl/acc_collector_if.sv
// Valid/ready word stream from the accumulator collector toward the host DMA.
interface acc_collector_if
    import hpu_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
);

    logic [DATA_W-1:0] m_tdata;
    logic              m_tvalid;
    logic              m_tlast;
    logic              m_tready;

    modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
    modport slave  (input m_tdata, input m_tvalid, input m_tlast, output m_tready);

endinterface

// File: rtl/acc_collector.sv
// Captures all core accumulators on an update pulse and streams them out, core 0 first.
// Updates arriving while a frame is still draining are dropped and flagged in overflow.
module acc_collector
    import hpu_pkg::*;
#(
    parameter int unsigned NUM_CORES = DEF_NUM_CORES,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        update,
    input  logic [NUM_CORES*DATA_W-1:0] acc_in,
    input  logic                        err_clr,
    acc_collector_if.master             m,
    output logic                        busy,
    output logic                        overflow,
    output logic [CNT_W-1:0]            frame_cnt
);

    localparam int unsigned     IW       = $clog2(NUM_CORES);
    localparam logic [IW-1:0]   LAST_IDX = IW'(NUM_CORES - 1);

    collector_state_t  state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d, idx_nxt;
    logic [DATA_W-1:0] buf_q [NUM_CORES];
    logic [DATA_W-1:0] tdata_q, tdata_d;
    logic              tvalid_q, tvalid_d;
    logic              tlast_q, tlast_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              capture;

    assign idx_nxt = idx_q + IW'(1);

    // Next state, capture strobe and the registered stream outputs.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q & ~err_clr;
        capture  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (update) begin
                    capture  = 1'b1;
                    idx_d    = '0;
                    tdata_d  = acc_in[DATA_W-1:0];
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    state_d  = DRAIN;
                end
            end
            DRAIN: begin
                if (m.m_tready && (idx_q == LAST_IDX)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    idx_d = '0;
                    if (update) begin
                        // Zero-bubble hand-over to the next frame.
                        capture = 1'b1;
                        tdata_d = acc_in[DATA_W-1:0];
                        tlast_d = 1'b0;
                    end else begin
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        state_d  = IDLE;
                    end
                end else begin
                    if (m.m_tready) begin
                        idx_d   = idx_nxt;
                        tdata_d = buf_q[idx_nxt];
                        tlast_d = (idx_nxt == LAST_IDX);
                    end
                    if (update) begin
                        ovf_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
        end
    end

    // Frame buffer holds data only; its contents are meaningless outside DRAIN.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int k = 0; k < NUM_CORES; k++) begin
                buf_q[k] <= acc_in[k*DATA_W +: DATA_W];
            end
        end
    end

    assign m.m_tdata  = tdata_q;
    assign m.m_tvalid = tvalid_q;
    assign m.m_tlast  = tlast_q;
    assign busy       = tvalid_q;
    assign overflow   = ovf_q;
    assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_acc_collector.sv
// Bench for acc_collector: directed scenarios plus random traffic against a queue-based frame model.
// A second instance with a 2-bit frame counter shares all stimulus to exercise counter wrap.
module tb_acc_collector;
    import hpu_pkg::*;

    localparam int unsigned NC = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               update;
    logic               err_clr;
    logic [NC*DW-1:0]   acc_in;
    logic               busy, busy2;
    logic               ovf, ovf2;
    logic [CW-1:0]      cnt;
    logic [1:0]         cnt2;

    acc_collector_if #(.DATA_W(DW)) s_if ();
    acc_collector_if #(.DATA_W(DW)) w_if ();

    assign w_if.m_tready = s_if.m_tready;

    always #5 clk = ~clk;

    acc_collector #(.NUM_CORES(NC), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .update(update), .acc_in(acc_in), .err_clr(err_clr),
        .m(s_if.master), .busy(busy), .overflow(ovf), .frame_cnt(cnt)
    );

    acc_collector #(.NUM_CORES(NC), .DATA_W(DW), .CNT_W(2)) dut_w (
        .clk(clk), .rst(rst), .update(update), .acc_in(acc_in), .err_clr(err_clr),
        .m(w_if.master), .busy(busy2), .overflow(ovf2), .frame_cnt(cnt2)
    );

    // Reference model: words still owed on the stream, frames completed, sticky error.
    logic [DW-1:0] exp_q [$];
    int unsigned   m_cnt;
    logic          m_ovf;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [NC*DW-1:0] make_frame(input logic [DW-1:0] base);
        logic [NC*DW-1:0] v;
        for (int k = 0; k < NC; k++) v[k*DW +: DW] = base + DW'(k);
        return v;
    endfunction

    function automatic logic [NC*DW-1:0] rand_frame();
        logic [NC*DW-1:0] v;
        for (int k = 0; k < NC; k++) v[k*DW +: DW] = $urandom;
        return v;
    endfunction

    task automatic model_step();
        bit hs, fin, drop;
        hs   = (exp_q.size() > 0) && s_if.m_tready;
        fin  = hs && (exp_q.size() == 1);
        drop = update && (exp_q.size() > 0) && !fin;
        if (hs) void'(exp_q.pop_front());
        if (fin) m_cnt++;
        if (update && !drop) begin
            for (int k = 0; k < NC; k++) exp_q.push_back(acc_in[k*DW +: DW]);
        end
        if (drop) m_ovf = 1'b1;
        else if (err_clr) m_ovf = 1'b0;
    endtask

    task automatic check_outputs();
        bit act;
        act = exp_q.size() > 0;
        chk("tvalid", 64'(s_if.m_tvalid), 64'(act));
        chk("busy", 64'(busy), 64'(act));
        chk("tlast", 64'(s_if.m_tlast), 64'(act && exp_q.size() == 1));
        if (act) begin
            chk("tdata", 64'(s_if.m_tdata), 64'(exp_q[0]));
            chk("tdata_w", 64'(w_if.m_tdata), 64'(exp_q[0]));
        end
        chk("tvalid_w", 64'(w_if.m_tvalid), 64'(act));
        chk("overflow", 64'(ovf), 64'(m_ovf));
        chk("frame_cnt", 64'(cnt), 64'(m_cnt % (1 << CW)));
        chk("frame_cnt_wrap", 64'(cnt2), 64'(m_cnt % 4));
    endtask

    // One clock: drive at the falling edge, model at the rising edge, check just after.
    task automatic tick(input logic upd, input logic [NC*DW-1:0] acc, input logic rdy, input logic clr);
        update        = upd;
        acc_in        = acc;
        s_if.m_tready = rdy;
        err_clr       = clr;
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_tvalid"}, 64'(s_if.m_tvalid), 64'd0);
        chk({tag, "_tlast"}, 64'(s_if.m_tlast), 64'd0);
        chk({tag, "_tdata"}, 64'(s_if.m_tdata), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_ovf"}, 64'(ovf), 64'd0);
        chk({tag, "_cnt"}, 64'(cnt), 64'd0);
        chk({tag, "_cnt_w"}, 64'(cnt2), 64'd0);
    endtask

    initial begin
        logic [3:0] bp_pat;
        bp_pat        = 4'b1001;
        rst           = 1'b0;
        update        = 1'b0;
        err_clr       = 1'b0;
        acc_in        = '0;
        s_if.m_tready = 1'b1;
        m_cnt         = 0;
        m_ovf         = 1'b0;

        #1 rst = 1'b1;
        #2 check_reset_values("reset");
        @(negedge clk);
        rst = 1'b0;

        // Basic frame with an always-ready sink.
        tick(1'b1, make_frame(32'h100), 1'b1, 1'b0);
        idle(9);

        // Backpressure with ready pattern 1,0,0,1 repeating.
        tick(1'b1, make_frame(32'h100), 1'b1, 1'b0);
        for (int i = 0; i < 24; i++) tick(1'b0, '0, bp_pat[i % 4], 1'b0);
        idle(4);

        // Back-to-back: second update lands on the final handshake.
        tick(1'b1, make_frame(32'h100), 1'b1, 1'b0);
        idle(7);
        tick(1'b1, make_frame(32'h200), 1'b1, 1'b0);
        idle(9);

        // Dropped update at idx 3, then clear the sticky flag.
        tick(1'b1, make_frame(32'h100), 1'b1, 1'b0);
        idle(3);
        tick(1'b1, make_frame(32'h300), 1'b1, 1'b0);
        idle(8);
        tick(1'b0, '0, 1'b1, 1'b1);
        idle(2);

        // Re-raise overflow and clear it in the same cycle as another drop: set wins.
        tick(1'b1, make_frame(32'h500), 1'b1, 1'b0);
        tick(1'b1, make_frame(32'h600), 1'b1, 1'b0);
        tick(1'b1, make_frame(32'h700), 1'b1, 1'b1);
        idle(8);
        tick(1'b0, '0, 1'b1, 1'b1);

        // Asynchronous reset while idx is 5.
        tick(1'b1, make_frame(32'h100), 1'b1, 1'b0);
        tick(1'b1, make_frame(32'h300), 1'b1, 1'b0);
        idle(4);
        #2 rst = 1'b1;
        #1 check_reset_values("midrst");
        exp_q.delete();
        m_cnt = 0;
        m_ovf = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick(1'b1, make_frame(32'h400), 1'b1, 1'b0);
        idle(9);

        // Random traffic; also pushes the narrow counter through several wraps.
        for (int i = 0; i < 3000; i++) begin
            logic upd, rdy, clr;
            rdy = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 15) == 0);
            if (exp_q.size() == 1 && rdy) upd = ($urandom_range(0, 1) == 0);
            else                          upd = ($urandom_range(0, 9) == 0);
            tick(upd, rand_frame(), rdy, clr);
        end
        idle(NC + 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
